// File: rtl/stream_realigner_pkg.sv
// Shared types and helpers for the stream realigner: FSM state, debug view,
// and keep-mask utilities sized for the widest supported beat (64 bytes).
package stream_realigner_pkg;

  localparam int MAX_BYTES = 64;
  localparam int CNT_W     = $clog2(MAX_BYTES + 1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    FLUSH,
    FLUSH_EMPTY
  } realigner_state_e;

  typedef struct packed {
    realigner_state_e state;
    logic             hold_valid;
  } realigner_dbg_t;

  // Number of valid bytes in a keep mask; only meaningful for contiguous keep.
  function automatic logic [CNT_W-1:0] keep_popcount(input logic [MAX_BYTES-1:0] keep);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      n = n + CNT_W'(keep[i]);
    end
    return n;
  endfunction

  function automatic logic [MAX_BYTES-1:0] low_mask(input logic [CNT_W-1:0] n);
    logic [MAX_BYTES-1:0] m;
    for (int i = 0; i < MAX_BYTES; i++) begin
      m[i] = (CNT_W'(i) < n);
    end
    return m;
  endfunction

endpackage

// File: rtl/stream_realigner_if.sv
// AXI4-Stream bundle used on both sides of the realigner.
// Handshake: a beat transfers on a rising clock edge where tvalid && tready;
// the master holds tdata/tkeep/tlast stable while tvalid && !tready, and
// tvalid never waits on tready.
interface stream_realigner_if #(
  parameter int WIDTH = 512
) ();
  localparam int BYTES = WIDTH / 8;

  logic [WIDTH-1:0] tdata;
  logic [BYTES-1:0] tkeep;
  logic             tlast;
  logic             tvalid;
  logic             tready;

  modport m (output tdata, output tkeep, output tlast, output tvalid, input tready);
  modport s (input tdata, input tkeep, input tlast, input tvalid, output tready);
endinterface

// File: rtl/stream_realigner_byte_funnel_select.sv
// Combinational funnel: picks BYTES consecutive lanes starting at lane sel
// out of {hi_lanes, lo_lanes}. LANE=8 for data bytes, LANE=1 for keep bits.
module stream_realigner_byte_funnel_select #(
  parameter int BYTES = 64,
  parameter int LANE  = 8,
  parameter int SEL_W = $clog2(BYTES)
) (
  input  logic [BYTES*LANE-1:0] lo_lanes,
  input  logic [BYTES*LANE-1:0] hi_lanes,
  input  logic [SEL_W-1:0]      sel,
  output logic [BYTES*LANE-1:0] out_lanes
);

  localparam int OUT_W = BYTES * LANE;
  localparam int SH_W  = $clog2(2 * OUT_W) + 1;

  logic [2*OUT_W-1:0] cat;
  logic [SH_W-1:0]    shamt;

  assign cat       = {hi_lanes, lo_lanes};
  assign shamt     = SH_W'(sel) * SH_W'(LANE);
  assign out_lanes = OUT_W'(cat >> shamt);

endmodule

// File: rtl/stream_realigner.sv
// Drops the first i_offset bytes of each AXI4-Stream packet and re-packs the
// remainder densely, funnelling each held beat with the next accepted one.
module stream_realigner
  import stream_realigner_pkg::*;
#(
  parameter int WIDTH        = 512,
  parameter int BYTES        = WIDTH / 8,
  parameter int OFFSET_WIDTH = $clog2(BYTES)
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [OFFSET_WIDTH-1:0] i_offset,
  stream_realigner_if.s           i_data,
  stream_realigner_if.m           o_data,
  output realigner_dbg_t          dbg
);

  realigner_state_e        state;
  logic                    hold_valid;
  logic [WIDTH-1:0]        hold_data;
  logic [BYTES-1:0]        hold_keep;
  logic [OFFSET_WIDTH-1:0] off_q;

  logic [WIDTH-1:0]        out_data;
  logic [BYTES-1:0]        out_keep;
  logic                    out_last;
  logic                    out_valid;

  logic                    out_free;
  logic                    in_ready;
  logic                    in_fire;
  logic [CNT_W-1:0]        in_vb;
  logic                    in_tail_fits;

  logic [WIDTH-1:0]        hi_data;
  logic [BYTES-1:0]        hi_keep;
  logic [WIDTH-1:0]        fun_data;
  logic [BYTES-1:0]        fun_keep;

  assign out_free = !out_valid || o_data.tready;
  assign in_ready = ((state == IDLE) || (state == HOLD)) && out_free;
  assign in_fire  = i_data.tvalid && in_ready;
  assign in_vb    = keep_popcount(MAX_BYTES'(i_data.tkeep));

  // Offset compared against the live input in IDLE, the latched one in HOLD.
  assign in_tail_fits = (state == IDLE) ? (in_vb > CNT_W'(i_offset))
                                        : (in_vb > CNT_W'(off_q));

  // In FLUSH the newer half is empty, so the held beat drains against zeros.
  assign hi_data = (state == HOLD) ? i_data.tdata : '0;
  assign hi_keep = (state == HOLD) ? i_data.tkeep : '0;

  stream_realigner_byte_funnel_select #(
    .BYTES (BYTES),
    .LANE  (8),
    .SEL_W (OFFSET_WIDTH)
  ) u_data_funnel (
    .lo_lanes  (hold_data),
    .hi_lanes  (hi_data),
    .sel       (off_q),
    .out_lanes (fun_data)
  );

  stream_realigner_byte_funnel_select #(
    .BYTES (BYTES),
    .LANE  (1),
    .SEL_W (OFFSET_WIDTH)
  ) u_keep_funnel (
    .lo_lanes  (hold_keep),
    .hi_lanes  (hi_keep),
    .sel       (off_q),
    .out_lanes (fun_keep)
  );

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state      <= IDLE;
      hold_valid <= 1'b0;
      hold_data  <= '0;
      hold_keep  <= '0;
      off_q      <= '0;
      out_data   <= '0;
      out_keep   <= '0;
      out_last   <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      if (out_valid && o_data.tready) begin
        out_valid <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (in_fire) begin
            off_q      <= i_offset;
            hold_data  <= i_data.tdata;
            hold_keep  <= i_data.tkeep;
            hold_valid <= 1'b1;
            if (!i_data.tlast)     state <= HOLD;
            else if (in_tail_fits) state <= FLUSH;
            else                   state <= FLUSH_EMPTY;
          end
        end
        HOLD: begin
          if (in_fire) begin
            out_data  <= fun_data;
            out_keep  <= fun_keep;
            out_valid <= 1'b1;
            hold_data <= i_data.tdata;
            hold_keep <= i_data.tkeep;
            // A short last beat is fully consumed by this emission.
            out_last  <= i_data.tlast && !in_tail_fits;
            if (i_data.tlast) begin
              if (in_tail_fits) begin
                state <= FLUSH;
              end else begin
                state      <= IDLE;
                hold_valid <= 1'b0;
              end
            end
          end
        end
        FLUSH: begin
          if (out_free) begin
            out_data   <= fun_data;
            out_keep   <= fun_keep;
            out_last   <= 1'b1;
            out_valid  <= 1'b1;
            state      <= IDLE;
            hold_valid <= 1'b0;
          end
        end
        FLUSH_EMPTY: begin
          if (out_free) begin
            out_data   <= '0;
            out_keep   <= '0;
            out_last   <= 1'b1;
            out_valid  <= 1'b1;
            state      <= IDLE;
            hold_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Keep must be contiguous from bit 0, and full on every non-last beat.
  always_ff @(posedge aclk) begin
    if (aresetn && in_fire) begin
      assert (i_data.tkeep == BYTES'(low_mask(in_vb)));
      assert (i_data.tlast || (&i_data.tkeep));
    end
  end

  assign o_data.tdata   = out_data;
  assign o_data.tkeep   = out_keep;
  assign o_data.tlast   = out_last;
  assign o_data.tvalid  = out_valid;
  assign i_data.tready  = in_ready;
  assign dbg.state      = state;
  assign dbg.hold_valid = hold_valid;

endmodule

// File: tb/tb_stream_realigner.sv
// Directed bench for stream_realigner: timed checks on hand-built packets,
// plus a byte-queue reference model feeding a scoreboard of output beats.
module tb_stream_realigner;
  import stream_realigner_pkg::*;

  localparam int W  = 512;
  localparam int B  = W / 8;
  localparam int OW = $clog2(B);

  logic           aclk;
  logic           aresetn;
  logic [OW-1:0]  i_offset;
  realigner_dbg_t dbg;

  stream_realigner_if #(.WIDTH(W)) in_if ();
  stream_realigner_if #(.WIDTH(W)) out_if ();

  stream_realigner #(.WIDTH(W)) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .i_offset (i_offset),
    .i_data   (in_if),
    .o_data   (out_if),
    .dbg      (dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- counters, queues ----------------
  int checks = 0;
  int errors = 0;
  bit rand_ready = 1'b0;

  logic [7:0]   pkt_q[$];
  logic [W-1:0] exp_q[$];
  logic [B-1:0] exp_keep_q[$];
  logic         exp_last_q[$];
  logic [W-1:0] obs_q[$];
  logic [B-1:0] obs_keep_q[$];
  logic         obs_last_q[$];

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output ready: changed just after the rising edge so it is stable at negedge.
  initial begin
    out_if.tready = 1'b1;
    forever begin
      @(posedge aclk);
      #2;
      out_if.tready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Monitor: records transferred beats and checks stability while stalled.
  initial begin : monitor
    bit           stall_prev;
    logic [W-1:0] snap_d;
    logic [B-1:0] snap_k;
    logic         snap_l;
    stall_prev = 1'b0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        stall_prev = 1'b0;
      end else if (out_if.tvalid) begin
        if (stall_prev) begin
          checks++;
          assert ((out_if.tdata === snap_d) && (out_if.tkeep === snap_k) && (out_if.tlast === snap_l))
          else begin
            errors++;
            $error("FAIL stall_stable: observed %0h/%0h/%0b expected %0h/%0h/%0b",
                   out_if.tdata, out_if.tkeep, out_if.tlast, snap_d, snap_k, snap_l);
          end
        end
        if (out_if.tready) begin
          obs_q.push_back(out_if.tdata);
          obs_keep_q.push_back(out_if.tkeep);
          obs_last_q.push_back(out_if.tlast);
        end
        stall_prev = !out_if.tready;
        snap_d = out_if.tdata;
        snap_k = out_if.tkeep;
        snap_l = out_if.tlast;
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  // ---------------- packet helpers and reference model ----------------
  task automatic fill_incr(input int n);
    pkt_q.delete();
    for (int i = 0; i < n; i++) pkt_q.push_back(8'(i));
  endtask

  task automatic fill_rand(input int n);
    pkt_q.delete();
    for (int i = 0; i < n; i++) pkt_q.push_back(8'($urandom_range(0, 255)));
  endtask

  function automatic logic [W-1:0] beat_data(input int b);
    logic [W-1:0] d = '0;
    for (int j = 0; j < B; j++)
      if (b * B + j < pkt_q.size()) d[j*8 +: 8] = pkt_q[b*B + j];
    return d;
  endfunction

  function automatic logic [B-1:0] beat_keep(input int b);
    logic [B-1:0] k = '0;
    for (int j = 0; j < B; j++)
      if (b * B + j < pkt_q.size()) k[j] = 1'b1;
    return k;
  endfunction

  // Drop off bytes, chop the rest into dense beats; empty remainder -> one null beat.
  task automatic model_pkt(input int off);
    int n;
    n = pkt_q.size() - off;
    if (n <= 0) begin
      exp_q.push_back('0);
      exp_keep_q.push_back('0);
      exp_last_q.push_back(1'b1);
    end else begin
      for (int s = off; s < pkt_q.size(); s += B) begin
        logic [W-1:0] d = '0;
        logic [B-1:0] k = '0;
        for (int j = 0; j < B; j++) begin
          if (s + j < pkt_q.size()) begin
            d[j*8 +: 8] = pkt_q[s + j];
            k[j] = 1'b1;
          end
        end
        exp_q.push_back(d);
        exp_keep_q.push_back(k);
        exp_last_q.push_back(s + B >= pkt_q.size());
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic send_beat(input logic [W-1:0] d, input logic [B-1:0] k, input logic l);
    int guard;
    guard = 0;
    in_if.tdata  = d;
    in_if.tkeep  = k;
    in_if.tlast  = l;
    in_if.tvalid = 1'b1;
    while (!in_if.tready && guard < 500) begin
      @(negedge aclk);
      guard++;
    end
    checks++;
    assert (guard < 500) else begin
      errors++;
      $error("FAIL accept_timeout: observed %0d cycles expected < 500", guard);
    end
    @(posedge aclk);
    @(negedge aclk);
    in_if.tvalid = 1'b0;
  endtask

  task automatic send_pkt(input int off, input int max_gap, input bit scramble_off);
    int nb;
    nb = (pkt_q.size() + B - 1) / B;
    i_offset = OW'(off);
    for (int b = 0; b < nb; b++) begin
      send_beat(beat_data(b), beat_keep(b), b == nb - 1);
      if (scramble_off) i_offset = OW'($urandom_range(0, B - 1));
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge aclk);
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic drain(input string tag);
    int guard;
    guard = 0;
    while (obs_q.size() < exp_q.size() && guard < 5000) begin
      @(negedge aclk);
      guard++;
    end
    repeat (4) @(negedge aclk);
    chk({tag, "_beat_count"}, W'(obs_q.size()), W'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      chk({tag, "_data"}, obs_q.pop_front(), exp_q.pop_front());
      chk({tag, "_keep"}, W'(obs_keep_q.pop_front()), W'(exp_keep_q.pop_front()));
      chk({tag, "_last"}, W'(obs_last_q.pop_front()), W'(exp_last_q.pop_front()));
    end
    obs_q.delete(); obs_keep_q.delete(); obs_last_q.delete();
    exp_q.delete(); exp_keep_q.delete(); exp_last_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    aresetn      = 1'b0;
    i_offset     = '0;
    in_if.tdata  = '0;
    in_if.tkeep  = '0;
    in_if.tlast  = 1'b0;
    in_if.tvalid = 1'b0;
    repeat (3) @(negedge aclk);
    chk("rst_tvalid", W'(out_if.tvalid), W'(1'b0));
    chk("rst_tlast",  W'(out_if.tlast),  W'(1'b0));
    chk("rst_tkeep",  W'(out_if.tkeep),  W'(0));
    chk("rst_state",  W'(dbg.state),     W'(IDLE));
    chk("rst_hold",   W'(dbg.hold_valid), W'(1'b0));
    aresetn = 1'b1;
    @(negedge aclk);

    // off=0, three full beats: passthrough delayed by one beat.
    fill_rand(3 * B);
    model_pkt(0);
    i_offset = '0;
    send_beat(beat_data(0), beat_keep(0), 1'b0);
    chk("t1_no_early_out", W'(out_if.tvalid), W'(1'b0));
    chk("t1_state_hold",   W'(dbg.state),     W'(HOLD));
    send_beat(beat_data(1), beat_keep(1), 1'b0);
    chk("t1_b0_valid", W'(out_if.tvalid), W'(1'b1));
    chk("t1_b0_data",  out_if.tdata,      beat_data(0));
    chk("t1_b0_last",  W'(out_if.tlast),  W'(1'b0));
    send_beat(beat_data(2), beat_keep(2), 1'b1);
    chk("t1_b1_data",  out_if.tdata,      beat_data(1));
    chk("t1_state_flush", W'(dbg.state),  W'(FLUSH));
    @(negedge aclk);
    chk("t1_b2_data",  out_if.tdata,      beat_data(2));
    chk("t1_b2_keep",  W'(out_if.tkeep),  W'(64'hFFFF_FFFF_FFFF_FFFF));
    chk("t1_b2_last",  W'(out_if.tlast),  W'(1'b1));
    drain("t1");

    // off=5, bytes 0..127 in two full beats.
    fill_incr(2 * B);
    model_pkt(5);
    i_offset = OW'(5);
    send_beat(beat_data(0), beat_keep(0), 1'b0);
    send_beat(beat_data(1), beat_keep(1), 1'b1);
    chk("t2_b0_byte0",  W'(out_if.tdata[7:0]),     W'(8'd5));
    chk("t2_b0_byte63", W'(out_if.tdata[511:504]), W'(8'd68));
    chk("t2_b0_keep",   W'(out_if.tkeep),          W'(64'hFFFF_FFFF_FFFF_FFFF));
    chk("t2_b0_last",   W'(out_if.tlast),          W'(1'b0));
    @(negedge aclk);
    chk("t2_b1_byte0",  W'(out_if.tdata[7:0]),     W'(8'd69));
    chk("t2_b1_byte58", W'(out_if.tdata[471:464]), W'(8'd127));
    chk("t2_b1_keep",   W'(out_if.tkeep),          W'(64'h07FF_FFFF_FFFF_FFFF));
    chk("t2_b1_last",   W'(out_if.tlast),          W'(1'b1));
    drain("t2");

    // off=63, single full beat: one byte survives.
    fill_incr(B);
    model_pkt(63);
    i_offset = OW'(63);
    send_beat(beat_data(0), beat_keep(0), 1'b1);
    @(negedge aclk);
    chk("t3_byte0", W'(out_if.tdata[7:0]), W'(8'd63));
    chk("t3_keep",  W'(out_if.tkeep),      W'(64'h1));
    chk("t3_last",  W'(out_if.tlast),      W'(1'b1));
    drain("t3");

    // off=10, single beat of 8 bytes: null beat, then an unaffected packet.
    fill_incr(8);
    model_pkt(10);
    i_offset = OW'(10);
    send_beat(beat_data(0), beat_keep(0), 1'b1);
    chk("t4_state_empty", W'(dbg.state), W'(FLUSH_EMPTY));
    @(negedge aclk);
    chk("t4_valid", W'(out_if.tvalid), W'(1'b1));
    chk("t4_keep",  W'(out_if.tkeep),  W'(0));
    chk("t4_data",  out_if.tdata,      W'(0));
    chk("t4_last",  W'(out_if.tlast),  W'(1'b1));
    fill_rand(100);
    model_pkt(10);
    send_pkt(10, 0, 1'b0);
    drain("t4");

    // Reset in HOLD after one emission; the next packet must carry no residue.
    fill_rand(3 * B);
    for (int j = 0; j < B; j++) begin
      if (j == 0) exp_q.push_back('0);
      exp_q[0][j*8 +: 8] = pkt_q[9 + j];
    end
    exp_keep_q.push_back('1);
    exp_last_q.push_back(1'b0);
    i_offset = OW'(9);
    send_beat(beat_data(0), beat_keep(0), 1'b0);
    send_beat(beat_data(1), beat_keep(1), 1'b0);
    #1;
    aresetn = 1'b0;
    @(negedge aclk);
    chk("t5_rst_tvalid", W'(out_if.tvalid),   W'(1'b0));
    chk("t5_rst_state",  W'(dbg.state),       W'(IDLE));
    chk("t5_rst_hold",   W'(dbg.hold_valid),  W'(1'b0));
    aresetn = 1'b1;
    @(negedge aclk);
    fill_rand(130);
    model_pkt(3);
    send_pkt(3, 0, 1'b0);
    drain("t5");

    // off=17: boundary lengths, then random packets with gaps and backpressure.
    rand_ready = 1'b1;
    fill_rand(B + 17);
    model_pkt(17);
    send_pkt(17, 2, 1'b1);
    fill_rand(17);
    model_pkt(17);
    send_pkt(17, 2, 1'b1);
    for (int p = 0; p < 20; p++) begin
      fill_rand($urandom_range(1, 4 * B));
      model_pkt(17);
      send_pkt(17, 2, 1'b1);
    end
    rand_ready = 1'b0;
    drain("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
